mux_arbiter: RTL and testbench

- Upstream companion of the registered 4:1 `mux`.
- Buffers one 64-bit word per source behind a valid/ready handshake.
- Picks one buffered source per cycle in round-robin order, then drives the mux's `ctrl` select and four data inputs.
- Produces `out_valid`, which lines up with the mux's registered output one cycle after the grant.

---
 rtl/mux_pkg.sv | 10 +
 rtl/mux_arbiter_if.sv | 35 +++
 rtl/mux.sv | 41 ++++
 rtl/mux_arbiter_rr_pick4.sv | 30 +++
 rtl/mux_arbiter.sv | 102 ++++++++++
 tb/tb_mux_arbiter.sv | 238 +++++++++++++++++++++++
 6 files changed

// File: rtl/mux_pkg.sv
// Shared widths and types for the registered 4:1 mux and its round-robin arbiter.
package mux_pkg;

    localparam int DATA_W = 64;
    localparam int N_SRC  = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux_arbiter_if.sv
// Bundle of the per-source handshake and the arbiter-to-mux signals.
// The master side feeds words and takes the mux-facing results; the slave side is the arbiter.
interface mux_arbiter_if #(
    parameter int DATA_W = mux_pkg::DATA_W
);
    import mux_pkg::*;

    logic [N_SRC-1:0]  in_valid;
    logic [N_SRC-1:0]  in_ready;
    logic [DATA_W-1:0] in_data0;
    logic [DATA_W-1:0] in_data1;
    logic [DATA_W-1:0] in_data2;
    logic [DATA_W-1:0] in_data3;
    logic              dn_ready;
    sel_t              ctrl;
    logic [DATA_W-1:0] buf_data0;
    logic [DATA_W-1:0] buf_data1;
    logic [DATA_W-1:0] buf_data2;
    logic [DATA_W-1:0] buf_data3;
    logic              out_valid;
    logic [N_SRC-1:0]  grant;

    modport master (
        output in_valid, in_data0, in_data1, in_data2, in_data3, dn_ready,
        input  in_ready, ctrl, buf_data0, buf_data1, buf_data2, buf_data3,
        input  out_valid, grant
    );

    modport slave (
        input  in_valid, in_data0, in_data1, in_data2, in_data3, dn_ready,
        output in_ready, ctrl, buf_data0, buf_data1, buf_data2, buf_data3,
        output out_valid, grant
    );

endinterface

// File: rtl/mux.sv
// Registered 4:1 word multiplexer; ctrl picks in1..in4 and the choice appears on out after the edge.
module mux
    import mux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  sel_t              ctrl,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic [DATA_W-1:0] in4,
    output logic [DATA_W-1:0] out
);

    logic [DATA_W-1:0] out_d;
    logic [DATA_W-1:0] out_q;

    // Select the input named by ctrl.
    always_comb begin
        out_d = in1;
        case (ctrl)
            2'd0: out_d = in1;
            2'd1: out_d = in2;
            2'd2: out_d = in3;
            2'd3: out_d = in4;
            default: out_d = in1;
        endcase
    end

    // Capture the selected word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/mux_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request at or above prio, wrapping 3 to 0.
module rr_pick4
    import mux_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  sel_t             prio,
    output logic [N_SRC-1:0] gnt,
    output sel_t             idx,
    output logic             any
);

    sel_t scan;

    // Walk the requests starting at prio and keep the first hit.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        scan = '0;
        for (int k = 0; k < N_SRC; k++) begin
            scan = prio + sel_t'(k);
            if (!any && req[scan]) begin
                gnt[scan] = 1'b1;
                idx       = scan;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arbiter.sv
// Buffers one word per source, grants one full buffer per cycle in round-robin order,
// and steers the downstream registered mux through ctrl and the buffer outputs.
module mux_arbiter #(
    parameter int DATA_W = mux_pkg::DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    mux_arbiter_if.slave  bus
);
    import mux_pkg::*;

    logic [N_SRC-1:0]  buf_vld_q;
    logic [N_SRC-1:0]  buf_vld_d;
    logic [DATA_W-1:0] buf_data_q [N_SRC];
    logic [DATA_W-1:0] buf_data_d [N_SRC];
    logic [DATA_W-1:0] in_data    [N_SRC];
    sel_t              prio_q;
    sel_t              prio_d;
    sel_t              last_sel_q;
    sel_t              last_sel_d;
    logic              out_valid_q;
    logic              out_valid_d;

    logic [N_SRC-1:0]  req;
    logic [N_SRC-1:0]  gnt;
    logic [N_SRC-1:0]  in_ready;
    logic [N_SRC-1:0]  in_xfer;
    sel_t              idx;
    logic              any;

    assign in_data[0] = bus.in_data0;
    assign in_data[1] = bus.in_data1;
    assign in_data[2] = bus.in_data2;
    assign in_data[3] = bus.in_data3;

    // Only full buffers compete, and nothing is granted while downstream is stalled.
    assign req = buf_vld_q & {N_SRC{bus.dn_ready}};

    rr_pick4 u_pick (
        .req  (req),
        .prio (prio_q),
        .gnt  (gnt),
        .idx  (idx),
        .any  (any)
    );

    // A granted buffer is drained this edge, so it may refill at the same time.
    assign in_ready = ~buf_vld_q | gnt;
    assign in_xfer  = bus.in_valid & in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.grant     = gnt;
    assign bus.ctrl      = any ? idx : last_sel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.buf_data0 = buf_data_q[0];
    assign bus.buf_data1 = buf_data_q[1];
    assign bus.buf_data2 = buf_data_q[2];
    assign bus.buf_data3 = buf_data_q[3];

    // Next buffer contents, round-robin pointer, held select and output-valid.
    always_comb begin
        buf_vld_d   = buf_vld_q;
        prio_d      = prio_q;
        last_sel_d  = last_sel_q;
        out_valid_d = any;
        for (int i = 0; i < N_SRC; i++) begin
            buf_data_d[i] = buf_data_q[i];
            if (in_xfer[i]) begin
                buf_data_d[i] = in_data[i];
                buf_vld_d[i]  = 1'b1;
            end else if (gnt[i]) begin
                buf_vld_d[i]  = 1'b0;
            end
        end
        if (any) begin
            prio_d     = idx + sel_t'(1);
            last_sel_d = idx;
        end
    end

    // State registers; reset drops any buffered words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_vld_q   <= '0;
            prio_q      <= '0;
            last_sel_q  <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < N_SRC; i++) begin
                buf_data_q[i] <= '0;
            end
        end else begin
            buf_vld_q   <= buf_vld_d;
            prio_q      <= prio_d;
            last_sel_q  <= last_sel_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < N_SRC; i++) begin
                buf_data_q[i] <= buf_data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter driving the registered mux; a queue of expected words
// is filled as grants are planned and drained whenever out_valid is seen.
module tb_mux_arbiter;
    import mux_pkg::*;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] mux_out;

    int vectors     = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] sb [$];

    mux_arbiter_if #(.DATA_W(DATA_W)) bus ();

    mux_arbiter #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mux u_mux (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus.ctrl),
        .in1  (bus.buf_data0),
        .in2  (bus.buf_data1),
        .in3  (bus.buf_data2),
        .in4  (bus.buf_data3),
        .out  (mux_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] vld, input logic [63:0] d0, input logic [63:0] d1,
                                 input logic [63:0] d2, input logic [63:0] d3);
        bus.in_valid = vld;
        bus.in_data0 = d0;
        bus.in_data1 = d1;
        bus.in_data2 = d2;
        bus.in_data3 = d3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetPulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Every word the mux presents with out_valid must be the next one planned.
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $error("[TB] FAIL unexpected_out observed=%h expected=none", mux_out);
            end else begin
                checkOutput("mux_out", mux_out, sb.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        bus.dn_ready = 1'b1;
        applyStimulus(4'b0000, '0, '0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ctrl", bus.ctrl, 0);
        checkOutput("rst_grant", bus.grant, 0);
        checkOutput("rst_in_ready", bus.in_ready, 4'b1111);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        tick();
        rst = 1'b0;

        $display("[TB] single word from source 2");
        applyStimulus(4'b0100, '0, '0, 64'hA5, '0);
        sb.push_back(64'hA5);
        tick();
        applyStimulus(4'b0000, '0, '0, '0, '0);
        @(negedge clk);
        checkOutput("t1_grant", bus.grant, 4'b0100);
        checkOutput("t1_ctrl", bus.ctrl, 2);
        checkOutput("t1_in_ready", bus.in_ready, 4'b1111);
        tick();
        @(negedge clk);
        checkOutput("t1_out_valid", bus.out_valid, 1);
        checkOutput("t1_grant_idle", bus.grant, 0);
        checkOutput("t1_ctrl_hold", bus.ctrl, 2);
        tick();

        $display("[TB] all four sources streaming");
        resetPulse();
        applyStimulus(4'b1111, 64'h10, 64'h11, 64'h12, 64'h13);
        tick();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checkOutput("t2_grant", bus.grant, 64'(4'b0001 << (k % 4)));
            if (k >= 1) checkOutput("t2_out_valid", bus.out_valid, 1);
            sb.push_back(64'h10 + 64'(k % 4));
            tick();
            if (k == 7) applyStimulus(4'b0000, 64'h10, 64'h11, 64'h12, 64'h13);
        end
        @(negedge clk);
        checkOutput("t2_last_valid", bus.out_valid, 1);
        checkOutput("t2_drained", bus.grant, 0);
        tick();

        $display("[TB] downstream stall with all sources sending");
        resetPulse();
        bus.dn_ready = 1'b0;
        applyStimulus(4'b1111, 64'h20, 64'h21, 64'h22, 64'h23);
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("t3_in_ready", bus.in_ready, 4'b0000);
            checkOutput("t3_grant", bus.grant, 0);
            checkOutput("t3_out_valid", bus.out_valid, 0);
            tick();
            applyStimulus(4'b1111, 64'h30, 64'h31, 64'h32, 64'h33);
        end
        bus.dn_ready = 1'b1;
        applyStimulus(4'b0000, '0, '0, '0, '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("t3_grant_rr", bus.grant, 64'(4'b0001 << k));
            sb.push_back(64'h20 + 64'(k));
            tick();
        end
        @(negedge clk);
        checkOutput("t3_last_valid", bus.out_valid, 1);
        tick();
        @(negedge clk);
        checkOutput("t3_idle", bus.out_valid, 0);

        $display("[TB] source 1 refills while granted");
        applyStimulus(4'b0010, '0, 64'h1, '0, '0);
        sb.push_back(64'h1);
        tick();
        applyStimulus(4'b0010, '0, 64'h2, '0, '0);
        sb.push_back(64'h2);
        @(negedge clk);
        checkOutput("t4_grant_a", bus.grant, 4'b0010);
        checkOutput("t4_in_ready", bus.in_ready, 4'b1111);
        tick();
        applyStimulus(4'b0000, '0, '0, '0, '0);
        @(negedge clk);
        checkOutput("t4_grant_b", bus.grant, 4'b0010);
        checkOutput("t4_valid_a", bus.out_valid, 1);
        tick();
        @(negedge clk);
        checkOutput("t4_valid_b", bus.out_valid, 1);
        checkOutput("t4_grant_idle", bus.grant, 0);
        tick();
        @(negedge clk);
        checkOutput("t4_idle", bus.out_valid, 0);

        $display("[TB] reset with buffers 0 and 3 full");
        applyStimulus(4'b1001, 64'h50, '0, '0, 64'h53);
        tick();
        @(negedge clk);
        checkOutput("t5_grant", bus.grant, 4'b1000);
        checkOutput("t5_ctrl", bus.ctrl, 3);
        tick();
        checkOutput("t5_pre_valid", bus.out_valid, 1);
        rst = 1'b1;
        applyStimulus(4'b0000, '0, '0, '0, '0);
        #1;
        checkOutput("t5_rst_valid", bus.out_valid, 0);
        checkOutput("t5_rst_in_ready", bus.in_ready, 4'b1111);
        checkOutput("t5_rst_ctrl", bus.ctrl, 0);
        checkOutput("t5_rst_grant", bus.grant, 0);
        @(negedge clk);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("t5_no_stale_valid", bus.out_valid, 0);
            checkOutput("t5_no_stale_grant", bus.grant, 0);
            tick();
        end

        $display("[TB] source 3 then source 0");
        applyStimulus(4'b1000, '0, '0, '0, 64'h63);
        sb.push_back(64'h63);
        tick();
        applyStimulus(4'b0000, '0, '0, '0, '0);
        @(negedge clk);
        checkOutput("t6_grant3", bus.grant, 4'b1000);
        checkOutput("t6_ctrl3", bus.ctrl, 3);
        tick();
        @(negedge clk);
        checkOutput("t6_ctrl_hold_a", bus.ctrl, 3);
        checkOutput("t6_grant_idle", bus.grant, 0);
        tick();
        @(negedge clk);
        checkOutput("t6_ctrl_hold_b", bus.ctrl, 3);
        tick();
        applyStimulus(4'b0001, 64'h60, '0, '0, '0);
        sb.push_back(64'h60);
        tick();
        applyStimulus(4'b0000, '0, '0, '0, '0);
        @(negedge clk);
        checkOutput("t6_grant0", bus.grant, 4'b0001);
        checkOutput("t6_ctrl0", bus.ctrl, 0);
        tick();
        @(negedge clk);
        checkOutput("t6_valid", bus.out_valid, 1);
        tick();
        @(negedge clk);

        checkOutput("sb_empty", 64'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
